// File: rtl/decode_stage_pipe.sv
// Decode stage: register file with write-back bypass, immediate sign extension, load-use hazard detection, ID/EX register.
// Latency: an accepted instruction appears on ex_* one cycle later; throughput 1/cycle absent hazards and stalls.
// Backpressure: ex_ready=0 holds ID/EX and drops in_ready; a load-use hazard inserts one bubble; flush always accepts.
// Optional: define DECODE_R0_ZERO_EN to hard-wire register 0 to zero (reads, bypass, write-back and hazard compare).
module decode_stage_pipe #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8,
    parameter int INST_W = 16,
    parameter int IMM_W  = 10,
    parameter int CTRL_W = 5,
    localparam int AW    = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] instruction,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [WIDTH-1:0]  ex_rdata1,
    output logic [WIDTH-1:0]  ex_rdata2,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [AW-1:0]     ex_rs1,
    output logic [AW-1:0]     ex_rs2,
    output logic [AW-1:0]     ex_rd
);

    // Fixed control-bundle bit positions; the remaining bits travel through untouched.
    localparam int CTRL_MEM_READ = 1;

    // ------------------------------------------------------------------
    // Instruction field extraction (rd shares the rs1 field)
    // ------------------------------------------------------------------
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [IMM_W-1:0] imm;
    logic [WIDTH-1:0] imm_ext;

    assign rs1     = instruction[INST_W-1 -: AW];
    assign rs2     = instruction[INST_W-AW-1 -: AW];
    assign imm     = instruction[IMM_W-1:0];
    assign imm_ext = WIDTH'($signed(imm));

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q [N_REGS];
    logic [WIDTH-1:0] regs_d [N_REGS];
    logic             wb_write;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;

`ifdef DECODE_R0_ZERO_EN
    assign wb_write = wb_en && (wb_addr != '0);
`else
    assign wb_write = wb_en;
`endif

    // Next register-file contents: one write port from write-back.
    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_write) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Register-file storage; every entry clears on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational operand reads with same-cycle write-back bypass.
    always_comb begin
        rdata1 = regs_q[rs1];
        rdata2 = regs_q[rs2];
        if (wb_en && (wb_addr == rs1)) begin
            rdata1 = wb_data;
        end
        if (wb_en && (wb_addr == rs2)) begin
            rdata2 = wb_data;
        end
`ifdef DECODE_R0_ZERO_EN
        if (rs1 == '0) begin
            rdata1 = '0;
        end
        if (rs2 == '0) begin
            rdata2 = '0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic [WIDTH-1:0]  ex_rdata1_q, ex_rdata1_d;
    logic [WIDTH-1:0]  ex_rdata2_q, ex_rdata2_d;
    logic [WIDTH-1:0]  ex_imm_q,   ex_imm_d;
    logic [AW-1:0]     ex_rs1_q,   ex_rs1_d;
    logic [AW-1:0]     ex_rs2_q,   ex_rs2_d;
    logic [AW-1:0]     ex_rd_q,    ex_rd_d;

    logic rd_match;
    logic hazard;
    logic advance;

`ifdef DECODE_R0_ZERO_EN
    assign rd_match = (ex_rd_q != '0) && ((ex_rd_q == rs1) || (ex_rd_q == rs2));
`else
    assign rd_match = (ex_rd_q == rs1) || (ex_rd_q == rs2);
`endif

    // A load still in ID/EX cannot supply its result to the instruction behind it.
    assign hazard   = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && in_valid && rd_match;
    assign advance  = !ex_valid_q || ex_ready;
    // A flush drops the incoming instruction, so it is always "accepted".
    assign in_ready = flush || (advance && !hazard);

    // ID/EX next state: flush > stall > bubble > load > drain.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_rdata1_d = ex_rdata1_q;
        ex_rdata2_d = ex_rdata2_q;
        ex_imm_d    = ex_imm_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_rd_d     = ex_rd_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (advance) begin
            if (hazard) begin
                // Bubble: data fields keep their values, only the valid drops.
                ex_valid_d = 1'b0;
            end else if (in_valid) begin
                ex_valid_d  = 1'b1;
                ex_ctrl_d   = ctrl_in;
                ex_rdata1_d = rdata1;
                ex_rdata2_d = rdata2;
                ex_imm_d    = imm_ext;
                ex_rs1_d    = rs1;
                ex_rs2_d    = rs2;
                ex_rd_d     = rs1;
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rdata1_q <= '0;
            ex_rdata2_q <= '0;
            ex_imm_q    <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_ctrl_q   <= ex_ctrl_d;
            ex_rdata1_q <= ex_rdata1_d;
            ex_rdata2_q <= ex_rdata2_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_rdata1 = ex_rdata1_q;
    assign ex_rdata2 = ex_rdata2_q;
    assign ex_imm    = ex_imm_q;
    assign ex_rs1    = ex_rs1_q;
    assign ex_rs2    = ex_rs2_q;
    assign ex_rd     = ex_rd_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed scenarios plus a long randomized run against a behavioural model.
// Latency: outputs checked 1 time unit after each rising edge; in_ready checked in the low clock phase.
// Backpressure: ex_ready, flush and load-use hazards are all exercised; every wait is bounded by clock count.
module tb_decode_stage_pipe;

    localparam int WIDTH = 16;
    localparam int NR    = 8;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       instruction = '0;
    logic [4:0]        ctrl_in = '0;
    logic              flush = 1'b0;
    logic              wb_en = 1'b0;
    logic [AW-1:0]     wb_addr = '0;
    logic [WIDTH-1:0]  wb_data = '0;
    logic              ex_valid;
    logic              ex_ready = 1'b1;
    logic [4:0]        ex_ctrl;
    logic [WIDTH-1:0]  ex_rdata1, ex_rdata2, ex_imm;
    logic [AW-1:0]     ex_rs1, ex_rs2, ex_rd;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .ctrl_in(ctrl_in), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ctrl(ex_ctrl),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_regs [NR];
    bit          m_v;
    logic [4:0]  m_ctrl;
    logic [15:0] m_r1, m_r2, m_imm;
    logic [2:0]  m_rs1, m_rs2, m_rd;

    function automatic logic [15:0] m_read(input logic [2:0] a, input bit we,
                                           input logic [2:0] wa, input logic [15:0] wd);
`ifdef DECODE_R0_ZERO_EN
        if (a == 3'd0) return 16'h0000;
`endif
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_v = 0; m_ctrl = '0; m_r1 = '0; m_r2 = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    endtask

    function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b, input logic [9:0] im);
        return {a, b, im};
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, ".ex_valid"},  ex_valid,  m_v);
        chk({tag, ".ex_ctrl"},   ex_ctrl,   m_ctrl);
        chk({tag, ".ex_rdata1"}, ex_rdata1, m_r1);
        chk({tag, ".ex_rdata2"}, ex_rdata2, m_r2);
        chk({tag, ".ex_imm"},    ex_imm,    m_imm);
        chk({tag, ".ex_rs1"},    ex_rs1,    m_rs1);
        chk({tag, ".ex_rs2"},    ex_rs2,    m_rs2);
        chk({tag, ".ex_rd"},     ex_rd,     m_rd);
    endtask

    task automatic set_idle();
        in_valid = 0; flush = 0; wb_en = 0; ex_ready = 1;
        instruction = '0; ctrl_in = '0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic set_random();
        in_valid = 1'($urandom); flush = 1'($urandom); wb_en = 1'($urandom);
        ex_ready = 1'($urandom); instruction = 16'($urandom); ctrl_in = 5'($urandom);
        wb_addr = 3'($urandom); wb_data = 16'($urandom);
    endtask

    // One clock of stimulus: check in_ready, advance the model, check ex_* after the edge.
    task automatic cycle(input string tag, input bit iv, input logic [15:0] ins, input logic [4:0] c,
                         input bit fl, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                         input bit er, output bit rdy_obs);
        logic [2:0] s1, s2;
        bit haz, go, exp_rdy;
        @(negedge clk);
        in_valid = iv; instruction = ins; ctrl_in = c; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; ex_ready = er;
        s1 = ins[15:13];
        s2 = ins[12:10];
        haz = m_v && m_ctrl[1] && iv && (s1 == m_rd || s2 == m_rd);
`ifdef DECODE_R0_ZERO_EN
        if (m_rd == 3'd0) haz = 0;
`endif
        go = !m_v || er;
        exp_rdy = fl || (go && !haz);
        #1;
        rdy_obs = in_ready;
        chk({tag, ".in_ready"}, in_ready, exp_rdy);
        if (fl) m_v = 0;
        else if (!go) m_v = m_v;
        else if (haz) m_v = 0;
        else if (iv) begin
            m_v = 1; m_ctrl = c;
            m_r1 = m_read(s1, we, wa, wd);
            m_r2 = m_read(s2, we, wa, wd);
            m_imm = 16'($signed(ins[9:0]));
            m_rs1 = s1; m_rs2 = s2; m_rd = s1;
        end else m_v = 0;
`ifdef DECODE_R0_ZERO_EN
        if (we && wa != 3'd0) m_regs[wa] = wd;
`else
        if (we) m_regs[wa] = wd;
`endif
        @(posedge clk);
        #1;
        chk_outputs(tag);
    endtask

    // Asynchronous reset under random activity; ex_* must clear without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        set_random();
        rst = 1'b0;
        #2;
        m_clear();
        chk_outputs("rst_async");
        @(posedge clk);
        set_random();
        #1;
        chk_outputs("rst_hold");
        @(negedge clk);
        set_idle();
        rst = 1'b1;
    endtask

    bit r;

    initial begin
        m_clear();
        do_reset();

        // Every register reads zero after reset.
        for (int i = 0; i < NR; i++) begin
            cycle("rd_zero", 1, mk(3'(i), 3'(i), 10'h0), 5'h0, 0, 0, 3'd0, 16'h0, 1, r);
            chk("rd_zero.const", ex_rdata1, 16'h0000);
        end

        // Write-back then decode, with negative and positive immediates.
        cycle("wb_r3", 0, 16'h0, 5'h0, 0, 1, 3'd3, 16'h1234, 1, r);
        cycle("dec_r3", 1, mk(3'd3, 3'd3, 10'h3FF), 5'h18, 0, 0, 3'd0, 16'h0, 1, r);
        chk("dec_r3.v",   ex_valid,  1'b1);
        chk("dec_r3.r1",  ex_rdata1, 16'h1234);
        chk("dec_r3.r2",  ex_rdata2, 16'h1234);
        chk("dec_r3.imm", ex_imm,    16'hFFFF);
        cycle("dec_pos", 1, mk(3'd3, 3'd3, 10'h1FF), 5'h0, 0, 0, 3'd0, 16'h0, 1, r);
        chk("dec_pos.imm", ex_imm, 16'h01FF);

        // Same-cycle bypass.
        cycle("bypass", 1, mk(3'd1, 3'd5, 10'h0), 5'h0, 0, 1, 3'd5, 16'hBEEF, 1, r);
        chk("bypass.r2", ex_rdata2, 16'hBEEF);

        // Load-use hazard: exactly one bubble.
        cycle("ld", 1, mk(3'd2, 3'd0, 10'h4), 5'h03, 0, 0, 3'd0, 16'h0, 1, r);
        cycle("use", 1, mk(3'd1, 3'd2, 10'h0), 5'h01, 0, 0, 3'd0, 16'h0, 1, r);
        chk("use.rdy", r, 1'b0);
        chk("use.bubble", ex_valid, 1'b0);
        cycle("use2", 1, mk(3'd1, 3'd2, 10'h0), 5'h01, 0, 0, 3'd0, 16'h0, 1, r);
        chk("use2.rdy", r, 1'b1);
        chk("use2.v", ex_valid, 1'b1);
        cycle("ld_b", 1, mk(3'd2, 3'd0, 10'h4), 5'h03, 0, 0, 3'd0, 16'h0, 1, r);
        cycle("nouse", 1, mk(3'd4, 3'd4, 10'h0), 5'h01, 0, 0, 3'd0, 16'h0, 1, r);
        chk("nouse.rdy", r, 1'b1);
        chk("nouse.v", ex_valid, 1'b1);

        // Downstream stall for three cycles, then release.
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1, mk(3'd6, 3'd7, 10'h55), 5'h10, 0, 0, 3'd0, 16'h0, 0, r);
            chk("stall.rdy", r, 1'b0);
            chk("stall.rs1", ex_rs1, 3'd4);
        end
        cycle("release", 1, mk(3'd6, 3'd7, 10'h55), 5'h10, 0, 0, 3'd0, 16'h0, 1, r);
        chk("release.rs1", ex_rs1, 3'd6);

        // Flush during a hazard, with a concurrent write-back.
        cycle("ld_f", 1, mk(3'd6, 3'd0, 10'h0), 5'h02, 0, 0, 3'd0, 16'h0, 1, r);
        cycle("flush", 1, mk(3'd6, 3'd6, 10'h0), 5'h0, 1, 1, 3'd7, 16'hCAFE, 0, r);
        chk("flush.rdy", r, 1'b1);
        chk("flush.v", ex_valid, 1'b0);
        cycle("after_fl", 1, mk(3'd7, 3'd1, 10'h0), 5'h0, 0, 0, 3'd0, 16'h0, 1, r);
        chk("after_fl.r1", ex_rdata1, 16'hCAFE);

        // Register 0 behaviour.
        cycle("wb_r0", 0, 16'h0, 5'h0, 0, 1, 3'd0, 16'hAAAA, 1, r);
        cycle("rd_r0", 1, mk(3'd0, 3'd0, 10'h0), 5'h0, 0, 0, 3'd0, 16'h0, 1, r);
`ifdef DECODE_R0_ZERO_EN
        chk("rd_r0.r1", ex_rdata1, 16'h0000);
`else
        chk("rd_r0.r1", ex_rdata1, 16'hAAAA);
`endif

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cycle("rand", $urandom_range(0, 9) < 8, 16'($urandom), 5'($urandom),
                  $urandom_range(0, 24) == 0, 1'($urandom), 3'($urandom), 16'($urandom),
                  $urandom_range(0, 3) != 0, r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
